// File: rtl/spi_reg_writer.sv
// SPI mode-0 register writer: shifts up to MAX_BITS of a left-justified payload out MSB first.
// Optional build macro SPI_REG_WRITER_VBLANK_GATE_EN adds i_vblank and only starts transfers during vertical blank.
module spi_reg_writer #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic [6:0]          i_len,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_ss_n,
    output logic                o_busy,
    output logic                o_done
`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
    ,
    input  logic                i_vblank
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_HOLD     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    localparam int         LEN_CAP   = (MAX_BITS < 127) ? MAX_BITS : 127;
    localparam logic [6:0] LEN_CAP_V = 7'(LEN_CAP);
    localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_timer;
    logic [7:0]            w_timer_nxt;
    logic [MAX_BITS-1:0]   r_shift;
    logic [MAX_BITS-1:0]   w_shift_nxt;
    logic [6:0]            r_len;
    logic [6:0]            w_len_nxt;
    logic [6:0]            r_rise;
    logic [6:0]            w_rise_nxt;
    logic [6:0]            w_len_clamp;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_gate;
    logic                  w_frame_nxt;

    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_ss_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ready;

`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
    assign w_gate = i_vblank;
`else
    assign w_gate = 1'b1;
`endif

    assign o_ready     = r_ready & w_gate;
    assign w_accept    = i_valid & o_ready;
    assign w_tick      = (r_timer == TICK_LAST);
    assign w_len_clamp = (i_len > LEN_CAP_V) ? LEN_CAP_V : i_len;
    assign w_frame_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT_HI) ||
                         (w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_HOLD);

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_ss_n = r_ss_n;
    assign o_busy = r_busy;
    assign o_done = r_done;

    // Next-state, shared timer, payload shift and rise-count logic.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_tick ? 8'd0 : (r_timer + 8'd1);
        w_shift_nxt = r_shift;
        w_len_nxt   = r_len;
        w_rise_nxt  = r_rise;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = 8'd0;
                if (w_accept) begin
                    w_len_nxt   = w_len_clamp;
                    w_shift_nxt = i_data;
                    w_rise_nxt  = 7'd0;
                    if (w_len_clamp == 7'd0) begin
                        // Empty request: jump straight to the last GAP cycle so done pulses next cycle.
                        w_state_nxt = S_GAP;
                        w_timer_nxt = TICK_LAST;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = S_SHIFT_HI;
                    w_rise_nxt  = r_rise + 7'd1;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SHIFT_HI: begin
                if (w_tick) begin
                    w_state_nxt = S_SHIFT_LO;
                    w_shift_nxt = {r_shift[MAX_BITS-2:0], 1'b0};
                end else begin
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_LO: begin
                if (w_tick) begin
                    if (r_rise == r_len) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_SHIFT_HI;
                        w_rise_nxt  = r_rise + 7'd1;
                    end
                end else begin
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = 8'd0;
            end
        endcase
    end

    // State, timer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            r_shift <= {MAX_BITS{1'b0}};
            r_len   <= 7'd0;
            r_rise  <= 7'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_shift <= w_shift_nxt;
            r_len   <= w_len_nxt;
            r_rise  <= w_rise_nxt;
        end
    end

    // Output flops decoded from the next state so SPI lines never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_sclk  <= (w_state_nxt == S_SHIFT_HI);
            r_mosi  <= w_frame_nxt ? w_shift_nxt[MAX_BITS-1] : 1'b0;
            r_ss_n  <= ~w_frame_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_GAP) && (w_timer_nxt == TICK_LAST);
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: a driver queues expected frames, a monitor decodes the SPI lines.
module tb_spi_reg_writer;

    localparam int DIV   = 2;
    localparam int DIV_B = 3;
    localparam int MB    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_sclk, a_mosi, a_ss_n, a_busy, a_done;
    logic [63:0] a_data;
    logic [6:0]  a_len;
    logic        b_valid, b_ready, b_sclk, b_mosi, b_ss_n, b_busy, b_done;
    logic [63:0] b_data;
    logic [6:0]  b_len;
`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
    logic        vblank;
`endif

    always #5 clk = ~clk;

    spi_reg_writer #(.CLK_DIV(DIV), .MAX_BITS(MB)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
        .i_data(a_data), .i_len(a_len), .o_sclk(a_sclk), .o_mosi(a_mosi),
        .o_ss_n(a_ss_n), .o_busy(a_busy), .o_done(a_done)
`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
        , .i_vblank(vblank)
`endif
    );

    spi_reg_writer #(.CLK_DIV(DIV_B), .MAX_BITS(MB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(b_data), .i_len(b_len), .o_sclk(b_sclk), .o_mosi(b_mosi),
        .o_ss_n(b_ss_n), .o_busy(b_busy), .o_done(b_done)
`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
        , .i_vblank(vblank)
`endif
    );

    typedef struct {
        logic [63:0] data;
        int          len;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for DUT A: decode frames and compare against the queued expectation on each done pulse.
    int          m_rises = 0, m_low = 0, m_high = 0, m_lat = 0, m_low_exp = 0;
    logic [63:0] m_rx = 64'd0;
    bit          m_prev_sclk = 1'b0, m_prev_ss = 1'b1, m_framed = 1'b0, m_after_done = 1'b0;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", a_ss_n === 1'b1 && a_sclk === 1'b0 && a_mosi === 1'b0 &&
                a_busy === 1'b0 && a_done === 1'b0,
                {a_ss_n, a_sclk, a_mosi, a_busy, a_done}, 5'b10000);
            m_rises = 0; m_low = 0; m_high = 0; m_rx = 64'd0;
            m_prev_sclk = 1'b0; m_prev_ss = 1'b1; m_framed = 1'b0; m_after_done = 1'b0;
        end else begin
            if (m_after_done) chk("ready_after_done", a_ready == 1'b1 && a_busy == 1'b0, {a_ready, a_busy}, 2'b10);
            m_after_done = 1'b0;
            if (a_sclk && !m_prev_sclk) begin
                m_rx = {m_rx[62:0], a_mosi};
                m_rises++;
            end
            if (!a_ss_n) m_low++;
            if (!a_ss_n && m_prev_ss) begin
                if (m_framed) chk("ss_gap_between_frames", m_high >= DIV, m_high, DIV);
                m_framed = 1'b1;
                m_high   = 0;
            end
            if (a_ss_n) begin
                m_high++;
                chk("lines_idle_when_deselected", !a_sclk && !a_mosi, {a_sclk, a_mosi}, 0);
            end
            if (a_done) begin
                chk("done_has_request", sb.size() != 0, sb.size(), 1);
                chk("busy_at_done", a_busy == 1'b1 && a_ready == 1'b0, {a_busy, a_ready}, 2'b10);
                if (sb.size() != 0) begin
                    m_e       = sb.pop_front();
                    m_lat     = (m_e.len > 0) ? DIV * (2 * m_e.len + 3) : 1;
                    m_low_exp = (m_e.len > 0) ? DIV * (2 * m_e.len + 2) : 0;
                    chk("done_latency", (cyc - m_e.acc) == m_lat, cyc - m_e.acc, m_lat);
                    chk("sclk_rise_count", m_rises == m_e.len, m_rises, m_e.len);
                    chk("ss_low_cycles", m_low == m_low_exp, m_low, m_low_exp);
                    if (m_e.len > 0) begin
                        chk("rx_bits", m_rx == (m_e.data >> (64 - m_e.len)), m_rx, m_e.data >> (64 - m_e.len));
                        chk("ss_high_to_done", m_high == DIV, m_high, DIV);
                    end
                end
                m_rises = 0; m_low = 0; m_rx = 64'd0;
                m_after_done = 1'b1;
            end
            m_prev_sclk = a_sclk;
            m_prev_ss   = a_ss_n;
        end
    end

    // Lightweight monitor for DUT B (CLK_DIV=3 back-to-back case).
    int b_rises = 0, b_high = 0, b_min = 1000, b_frames = 0, b_dones = 0;
    bit bp_sclk = 1'b0, bp_ss = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_sclk && !bp_sclk) b_rises++;
            if (!b_ss_n && bp_ss) begin
                if (b_frames > 0 && b_high < b_min) b_min = b_high;
                b_frames++;
                b_high = 0;
            end
            if (b_ss_n) b_high++;
            if (b_done) b_dones++;
            bp_sclk = b_sclk;
            bp_ss   = b_ss_n;
        end
    end

    task automatic send_a(input logic [63:0] d, input int l, input bit keep);
        int   w;
        exp_t e;
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = d;
        a_len   = 7'(l);
        #1;
        w = 0;
        while (!a_ready && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept_within_budget", a_ready == 1'b1, w, 3000);
        if (a_ready) begin
            e.data = d;
            e.len  = (l > MB) ? MB : l;
            e.acc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        a_valid = keep;
        a_data  = {$urandom, $urandom};
        a_len   = 7'($urandom_range(0, 127));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("all_frames_done", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; a_valid = 1'b0; a_data = 64'd0; a_len = 7'd0;
        b_valid = 1'b0; b_data = 64'd0; b_len = 7'd0;
`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
        vblank = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_out_of_reset", a_ready == 1'b1 && a_ss_n == 1'b1 && a_sclk == 1'b0 && a_busy == 1'b0,
            {a_ready, a_ss_n, a_sclk, a_busy}, 4'b1100);

        send_a(64'hA500_0000_0000_0000, 8, 1'b0);
        drain();
        send_a({$urandom, $urandom}, 0, 1'b0);
        drain();
        send_a({$urandom, $urandom}, 100, 1'b0);
        drain();
        send_a({$urandom, $urandom}, 5, 1'b1);
        send_a({$urandom, $urandom}, 3, 1'b0);
        drain();

`ifdef SPI_REG_WRITER_VBLANK_GATE_EN
        begin
            exp_t e;
            bit   held;
            @(negedge clk);
            vblank  = 1'b0;
            a_valid = 1'b1;
            a_data  = {$urandom, $urandom};
            a_len   = 7'd4;
            held    = 1'b1;
            repeat (50) begin
                @(negedge clk);
                if (!a_ss_n || a_ready) held = 1'b0;
            end
            chk("vblank_blocks_start", held, held, 1);
            vblank = 1'b1;
            #1;
            chk("vblank_ready", a_ready == 1'b1, a_ready, 1);
            if (a_ready) begin
                e.data = a_data; e.len = 4; e.acc = cyc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            a_valid = 1'b0;
            w = 0;
            while (a_ss_n && w < 2) begin
                @(negedge clk);
                w++;
            end
            chk("vblank_start_latency", a_ss_n == 1'b0, w, 2);
            drain();
        end
`endif

        send_a({$urandom, $urandom}, 20, 1'b0);
        w = 0;
        while (m_rises < 3 && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("third_rise_seen", m_rises == 3, m_rises, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_lines_idle", a_ss_n == 1'b1 && a_sclk == 1'b0 && a_busy == 1'b0 && a_done == 1'b0,
            {a_ss_n, a_sclk, a_busy, a_done}, 4'b1000);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_abort", a_ready == 1'b1 && a_ss_n == 1'b1, {a_ready, a_ss_n}, 2'b11);
        repeat (20) @(negedge clk);

        b_valid = 1'b1;
        b_data  = {$urandom, $urandom};
        b_len   = 7'd8;
        #1;
        w = 0;
        while (!b_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        b_data = {$urandom, $urandom};
        b_len  = 7'd6;
        @(negedge clk);
        #1;
        w = 0;
        while (!b_ready && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        w = 0;
        while (b_dones < 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        chk("b2b_done_pulses", b_dones == 2, b_dones, 2);
        chk("b2b_frames", b_frames == 2, b_frames, 2);
        chk("b2b_rises", b_rises == 14, b_rises, 14);
        chk("b2b_min_gap", b_min >= DIV_B, b_min, DIV_B);

        for (int i = 0; i < 16; i++) begin
            send_a({$urandom, $urandom}, $urandom_range(0, 100), (i != 15) && ($urandom_range(0, 3) == 0));
        end
        a_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
